// File: rtl/mvp_seq_pkg.sv
// mvp_pkg: shared state encoding, token type and precision helper for mvp_seq
package mvp_pkg;
    localparam int MAXP_DEF = 8;
    // token shift width follows the default precision: max shift is 2*(MAXP_DEF-1)
    localparam int TSW = $clog2(2 * MAXP_DEF - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    typedef struct packed {
        logic           valid;
        logic           first;
        logic           last;
        logic [TSW-1:0] shamt;
    } token_t;

    function automatic int clamp_prec(int p, int maxp);
        return p == 0 ? 1 : (p > maxp ? maxp : p);
    endfunction
endpackage

// File: rtl/mvp_seq_if.sv
// mvp_seq_if: job, plane-issue and accumulate signals between front-end and sequencer
interface mvp_seq_if import mvp_pkg::*; #(parameter int MAXP = MAXP_DEF);
    localparam int PW = $clog2(MAXP + 1);
    localparam int IW = $clog2(MAXP);
    localparam int SW = $clog2(2 * MAXP - 1);

    logic          start;
    logic [PW-1:0] wprec;
    logic [PW-1:0] dprec;
    logic          w_signed;
    logic          d_signed;
    logic          stall;
    logic          busy;
    logic          issue;
    logic [IW-1:0] w_idx;
    logic [IW-1:0] d_idx;
    logic [1:0]    mode;
    logic          acc_clr;
    logic          acc_en;
    logic [SW-1:0] acc_shamt;
    logic          done;

    modport master (
        output start, wprec, dprec, w_signed, d_signed, stall,
        input  busy, issue, w_idx, d_idx, mode, acc_clr, acc_en, acc_shamt, done
    );

    modport slave (
        input  start, wprec, dprec, w_signed, d_signed, stall,
        output busy, issue, w_idx, d_idx, mode, acc_clr, acc_en, acc_shamt, done
    );
endinterface

// File: rtl/mvp_seq_dly.sv
// mvp_seq_dly: LAT-deep token pipeline matching the array latency (LAT=0 is a wire)
module mvp_seq_dly import mvp_pkg::*; #(
    parameter int LAT = 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  token_t d,
    output token_t q
);
    generate
        if (LAT == 0) begin : g_pass
            wire unused_clk = &{1'b0, clk, rst_n};
            assign q = d;
        end else begin : g_pipe
            token_t pipe [LAT];
            // advance every token one stage per cycle, bubbles included
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign q = pipe[LAT-1];
        end
    endgenerate
endmodule

// File: rtl/mvp_seq.sv
// mvp_seq: bit-serial plane-pair sequencer; MVP_SEQ_PERF_EN adds perf_cycles/perf_stalls
module mvp_seq import mvp_pkg::*; #(
    parameter int MAXP = MAXP_DEF,
    parameter int LAT  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MVP_SEQ_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [15:0] perf_stalls,
`endif
    mvp_seq_if.slave    bus
);
    localparam int PW = $clog2(MAXP + 1);
    localparam int IW = $clog2(MAXP);
    localparam int SW = $clog2(2 * MAXP - 1);

    state_t        state;
    logic [PW-1:0] wp, dp;
    logic [IW-1:0] wi, di;
    logic          ws, ds, first_f;
    logic          issue, accept;
    token_t        tin, tout;

    assign issue  = state == ISSUE && !bus.stall;
    // a new job may start in IDLE or on the edge that retires the previous job's last token
    assign accept = bus.start && (state == IDLE || tout.last);

    assign tin = '{valid: issue,
                   first: issue && first_f,
                   last:  issue && wi == '0 && di == '0,
                   shamt: issue ? TSW'(wi) + TSW'(di) : '0};

    mvp_seq_dly #(.LAT(LAT)) u_dly (.clk(clk), .rst_n(rst_n), .d(tin), .q(tout));

    assign bus.busy      = state != IDLE;
    assign bus.issue     = issue;
    assign bus.w_idx     = issue ? wi : '0;
    assign bus.d_idx     = issue ? di : '0;
    assign bus.mode      = issue ? {ds && di == IW'(dp - 1'b1), ws && wi == IW'(wp - 1'b1)} : 2'b00;
    assign bus.acc_en    = tout.valid;
    assign bus.acc_clr   = tout.first;
    assign bus.done      = tout.last;
    assign bus.acc_shamt = SW'(tout.shamt);

    // job FSM: latch clamped precisions, walk planes MSB-first with di innermost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wp      <= '0;
            dp      <= '0;
            wi      <= '0;
            di      <= '0;
            ws      <= 1'b0;
            ds      <= 1'b0;
            first_f <= 1'b0;
        end else if (accept) begin
            state   <= ISSUE;
            wp      <= PW'(clamp_prec(int'(bus.wprec), MAXP));
            dp      <= PW'(clamp_prec(int'(bus.dprec), MAXP));
            wi      <= IW'(clamp_prec(int'(bus.wprec), MAXP) - 1);
            di      <= IW'(clamp_prec(int'(bus.dprec), MAXP) - 1);
            ws      <= bus.w_signed;
            ds      <= bus.d_signed;
            first_f <= 1'b1;
        end else begin
            case (state)
                ISSUE: if (issue) begin
                    first_f <= 1'b0;
                    if (di == '0) begin
                        di <= IW'(dp - 1'b1);
                        if (wi == '0) state <= (LAT == 0) ? IDLE : DRAIN;
                        else wi <= wi - 1'b1;
                    end else begin
                        di <= di - 1'b1;
                    end
                end
                DRAIN: if (tout.last) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MVP_SEQ_PERF_EN
    logic [31:0] cyc_cnt;
    logic [15:0] stl_cnt;

    // saturating busy/stall counters, published when the job's done pulse fires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt     <= '0;
            stl_cnt     <= '0;
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else begin
            if (tout.last) begin
                perf_cycles <= cyc_cnt == '1 ? cyc_cnt : cyc_cnt + 1'b1;
                perf_stalls <= stl_cnt;
            end
            cyc_cnt <= accept ? '0 : (bus.busy && cyc_cnt != '1) ? cyc_cnt + 1'b1 : cyc_cnt;
            stl_cnt <= accept ? '0 : (state == ISSUE && bus.stall && stl_cnt != '1) ? stl_cnt + 1'b1 : stl_cnt;
        end
    end
`endif
endmodule

// File: tb/tb_mvp_seq.sv
// tb_mvp_seq: four sequencers (LAT 0..3) on shared stimulus, checked against a plane-count model
module tb_mvp_seq;
    import mvp_pkg::*;

    localparam int MAXP = 8;
    localparam int NL   = 4;
    localparam int PW   = $clog2(MAXP + 1);
    localparam int IW   = $clog2(MAXP);
    localparam int SW   = $clog2(2 * MAXP - 1);

    typedef struct packed {
        logic          v;
        logic          f;
        logic          l;
        logic [SW-1:0] s;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b1;
    logic start = 1'b0, w_signed = 1'b0, d_signed = 1'b0, stall = 1'b0;
    logic [PW-1:0] wprec = '0, dprec = '0;

    logic          o_busy [NL], o_issue [NL], o_clr [NL], o_en [NL], o_done [NL];
    logic [IW-1:0] o_wi [NL], o_di [NL];
    logic [1:0]    o_mode [NL];
    logic [SW-1:0] o_sh [NL];
`ifdef MVP_SEQ_PERF_EN
    logic [31:0]   o_pc [NL];
    logic [15:0]   o_ps [NL];
`endif

    int passed = 0, total = 0, fails = 0, cyc = 0;
    bit mb [NL], mws [NL], mds [NL];
    int mn [NL], mwp [NL], mdp [NL], pcnt [NL], scnt [NL], epc [NL], eps [NL];
    exp_t slot [NL][16];

    always #5 clk = ~clk;

    mvp_seq_if #(.MAXP(MAXP)) bus [NL] ();

    genvar g;
    generate
        for (g = 0; g < NL; g++) begin : gd
            assign bus[g].start    = start;
            assign bus[g].wprec    = wprec;
            assign bus[g].dprec    = dprec;
            assign bus[g].w_signed = w_signed;
            assign bus[g].d_signed = d_signed;
            assign bus[g].stall    = stall;
            assign o_busy[g]  = bus[g].busy;
            assign o_issue[g] = bus[g].issue;
            assign o_wi[g]    = bus[g].w_idx;
            assign o_di[g]    = bus[g].d_idx;
            assign o_mode[g]  = bus[g].mode;
            assign o_clr[g]   = bus[g].acc_clr;
            assign o_en[g]    = bus[g].acc_en;
            assign o_sh[g]    = bus[g].acc_shamt;
            assign o_done[g]  = bus[g].done;
            mvp_seq #(.MAXP(MAXP), .LAT(g)) dut (
                .clk(clk),
                .rst_n(rst_n),
`ifdef MVP_SEQ_PERF_EN
                .perf_cycles(o_pc[g]),
                .perf_stalls(o_ps[g]),
`endif
                .bus(bus[g])
            );
        end
    endgenerate

    function automatic int clampv(int p);
        return p == 0 ? 1 : (p > MAXP ? MAXP : p);
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s lat=%0d cycle=%0d observed=%0h expected=%0h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic chk_all(input int k, input exp_t t, input bit iss, input int w, input int d, input logic [1:0] m);
        chk("busy", k, 32'(o_busy[k]), 32'(mb[k]));
        chk("issue", k, 32'(o_issue[k]), 32'(iss));
        chk("w_idx", k, 32'(o_wi[k]), 32'(w));
        chk("d_idx", k, 32'(o_di[k]), 32'(d));
        chk("mode", k, 32'(o_mode[k]), 32'(m));
        chk("acc_en", k, 32'(o_en[k]), 32'(t.v));
        chk("acc_clr", k, 32'(o_clr[k]), 32'(t.f));
        chk("acc_shamt", k, 32'(o_sh[k]), 32'(t.s));
        chk("done", k, 32'(o_done[k]), 32'(t.l));
`ifdef MVP_SEQ_PERF_EN
        chk("perf_cycles", k, o_pc[k], 32'(epc[k]));
        chk("perf_stalls", k, 32'(o_ps[k]), 32'(eps[k]));
`endif
    endtask

    // one clock: drive inputs, compare mid-cycle, then advance the model at the edge
    task automatic cycle(input bit st, input bit stl);
        bit isa [NL];
        bit dn [NL];
        start = st;
        stall = stl;
        @(negedge clk);
        for (int k = 0; k < NL; k++) begin
            int p, w, d;
            logic [1:0] m;
            exp_t t;
            p = mwp[k] * mdp[k];
            isa[k] = mb[k] && mn[k] < p && !stl;
            w = isa[k] ? mwp[k] - 1 - mn[k] / mdp[k] : 0;
            d = isa[k] ? mdp[k] - 1 - mn[k] % mdp[k] : 0;
            m = isa[k] ? {mds[k] && d == mdp[k] - 1, mws[k] && w == mwp[k] - 1} : 2'b00;
            if (isa[k]) slot[k][(cyc + k) % 16] = '{1'b1, mn[k] == 0, mn[k] == p - 1, SW'(w + d)};
            t = slot[k][cyc % 16];
            slot[k][cyc % 16] = '0;
            dn[k] = t.l;
            chk_all(k, t, isa[k], w, d, m);
            if (mb[k]) pcnt[k]++;
            if (mb[k] && mn[k] < p && stl) scnt[k]++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NL; k++) begin
            if (isa[k]) mn[k]++;
            if (dn[k]) begin
                epc[k] = pcnt[k];
                eps[k] = scnt[k];
            end
            if (st && (!mb[k] || dn[k])) begin
                mb[k]   = 1'b1;
                mn[k]   = 0;
                mwp[k]  = clampv(int'(wprec));
                mdp[k]  = clampv(int'(dprec));
                mws[k]  = w_signed;
                mds[k]  = d_signed;
                pcnt[k] = 0;
                scnt[k] = 0;
            end else if (dn[k]) begin
                mb[k] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        exp_t z;
        z = '0;
        rst_n = 1'b0;
        #2;
        for (int k = 0; k < NL; k++) begin
            mb[k] = 1'b0;
            mn[k] = 0;
            mwp[k] = 1;
            mdp[k] = 1;
            epc[k] = 0;
            eps[k] = 0;
            pcnt[k] = 0;
            scnt[k] = 0;
            for (int j = 0; j < 16; j++) slot[k][j] = '0;
            chk_all(k, z, 1'b0, 0, 0, 2'b00);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    task automatic job(input int wp, input int dp, input bit ws, input bit ds, input int s0, input int s1, input int n);
        wprec = PW'(wp);
        dprec = PW'(dp);
        w_signed = ws;
        d_signed = ds;
        cycle(1'b1, 1'b0);
        for (int i = 1; i <= n; i++) cycle(1'b0, i >= s0 && i <= s1);
    endtask

    initial begin
        #1;
        do_reset();
        job(2, 2, 1'b0, 1'b0, -1, -1, 10);
        job(3, 1, 1'b1, 1'b1, -1, -1, 8);
        job(2, 2, 1'b0, 1'b0, 2, 3, 12);
        job(0, 9, 1'b0, 1'b0, -1, -1, 14);
        wprec = PW'(2);
        dprec = PW'(3);
        repeat (20) cycle(1'b1, 1'b0);
        repeat (12) cycle(1'b0, 1'b0);
        wprec = PW'(4);
        dprec = PW'(4);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        do_reset();
        job(2, 3, 1'b1, 1'b0, -1, -1, 12);
        wprec = PW'(1);
        dprec = PW'(1);
        repeat (12) cycle(1'b1, 1'b0);
        repeat (6) cycle(1'b0, 1'b0);
        repeat (800) begin
            wprec = PW'($urandom_range(0, 9));
            dprec = PW'($urandom_range(0, 9));
            w_signed = 1'($urandom_range(0, 1));
            d_signed = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 199) == 0) do_reset();
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end
        repeat (20) cycle(1'b0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
